// File: rtl/ccff_loader.sv
// Configuration chain loader: streams host words MSB-first into a ccff chain
// and optionally recirculates the chain once to compare a ones-count checksum.
module ccff_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(CHAIN_LEN - 1);
    localparam logic [WW-1:0] LAST_WBIT = WW'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        VERIFY,
        FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WORD_W-1:0] sreg;
    logic [CW-1:0]     bit_cnt;
    logic [CW-1:0]     vrf_cnt;
    logic [CW-1:0]     ones_ld;
    logic [CW-1:0]     ones_rb;
    logic [CW-1:0]     ones_rb_nx;
    logic [WW-1:0]     word_cnt;
    logic              vrf_lat;
    logic              last_bit;
    logic              last_wbit;
    logic              last_vrf;
    logic              mismatch;

    assign last_bit   = (bit_cnt == LAST_BIT);
    assign last_wbit  = (word_cnt == LAST_WBIT);
    assign last_vrf   = (vrf_cnt == LAST_BIT);
    // The final readback bit is still on ccff_tail when the compare is made.
    assign ones_rb_nx = ones_rb + CW'(ccff_tail);
    assign mismatch   = (ones_rb_nx != ones_ld);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        chain_en  = 1'b0;
        ccff_head = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                chain_en  = 1'b1;
                ccff_head = sreg[WORD_W-1];
                if (last_bit) begin
                    state_nx = vrf_lat ? VERIFY : FINISH;
                end else if (last_wbit) begin
                    state_nx = LOAD;
                end
            end
            VERIFY: begin
                // Tail fed back to head: one full lap leaves the chain intact.
                chain_en  = 1'b1;
                ccff_head = ccff_tail;
                if (last_vrf) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            vrf_cnt  <= '0;
            ones_ld  <= '0;
            ones_rb  <= '0;
            word_cnt <= '0;
            vrf_lat  <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vrf_lat  <= verify_en;
                        err      <= 1'b0;
                        sreg     <= '0;
                        bit_cnt  <= '0;
                        vrf_cnt  <= '0;
                        ones_ld  <= '0;
                        ones_rb  <= '0;
                        word_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        sreg     <= cfg_data;
                        word_cnt <= '0;
                    end
                end
                SHIFT: begin
                    sreg     <= sreg << 1;
                    bit_cnt  <= bit_cnt + CW'(1);
                    word_cnt <= word_cnt + WW'(1);
                    ones_ld  <= ones_ld + CW'(sreg[WORD_W-1]);
                end
                VERIFY: begin
                    vrf_cnt <= vrf_cnt + CW'(1);
                    ones_rb <= ones_rb_nx;
                    if (last_vrf && mismatch) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed and random load sessions against a chain model and a
// bit-stream reference built from the word list.
module tb_ccff_loader;

    localparam int CL = 20;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;
    localparam logic [CL-1:0] FLIP = CL'(1) << 10;

    logic          prog_clk = 1'b0;
    logic          pReset_n = 1'b0;
    logic          start = 1'b0;
    logic          verify_en = 1'b0;
    logic [WW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          ccff_head;
    logic          chain_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    logic [CL-1:0] chain = '0;
    logic          s_en = 1'b0;
    logic          s_head = 1'b0;
    logic          flip_req = 1'b0;
    bit            cap[$];

    logic [WW-1:0] wq[NW];
    int            gq[NW];

    ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .start    (start),
        .verify_en(verify_en),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .ccff_head(ccff_head),
        .chain_en (chain_en),
        .ccff_tail(ccff_tail),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 prog_clk = ~prog_clk;

    assign ccff_tail = chain[CL-1];

    always @(negedge prog_clk) begin
        s_en   = chain_en;
        s_head = ccff_head;
    end

    always @(posedge prog_clk) begin
        if (s_en) begin
            chain <= {chain[CL-2:0], s_head} ^ (flip_req ? FLIP : '0);
            cap.push_back(s_head);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_session(input bit ven, input bit flip, input bit poke);
        bit            eb[$];
        logic [CL-1:0] expv;
        logic [CL-1:0] got;
        int            base;
        int            t;
        int            ld;
        int            rb;
        bit            xready;
        bit            flipped;
        eb.delete();
        for (int k = 0; k < NW; k++)
            for (int b = WW - 1; b >= 0; b--)
                if (eb.size() < CL) eb.push_back(wq[k][b]);
        expv = '0;
        ld = 0;
        rb = 0;
        for (int i = 0; i < CL; i++) begin
            expv[CL-1-i] = eb[i];
            ld += int'(eb[i]);
            rb += int'((i == 10 && flip) ? !eb[i] : eb[i]);
        end
        base = cap.size();
        @(negedge prog_clk);
        start = 1'b1;
        verify_en = ven;
        @(negedge prog_clk);
        start = 1'b0;
        verify_en = 1'($urandom);
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        for (int k = 0; k < NW; k++) begin
            if (poke && k == 1) start = 1'b1;
            t = 0;
            while (!cfg_ready && t < 4 * WW) begin
                @(negedge prog_clk);
                t++;
            end
            chk("ready_wait", cfg_ready, 1);
            for (int g = 0; g < gq[k]; g++) begin
                cfg_data = WW'($urandom);
                chk("stall_ready", cfg_ready, 1);
                chk("stall_chain_en", chain_en, 0);
                @(negedge prog_clk);
            end
            cfg_valid = 1'b1;
            cfg_data = wq[k];
            @(negedge prog_clk);
            cfg_valid = 1'b0;
            cfg_data = WW'($urandom);
            start = 1'b0;
            chk("head_msb", ccff_head, wq[k][WW-1]);
            chk("shift_en", chain_en, 1);
        end
        t = 0;
        xready = 0;
        flipped = 0;
        while (!done && t < 3 * CL + 10) begin
            xready |= cfg_ready;
            if (flip && !flipped && cap.size() - base == CL) begin
                flip_req = 1'b1;
                flipped = 1;
            end
            @(negedge prog_clk);
            flip_req = 1'b0;
            t++;
        end
        chk("done_pulse", done, 1);
        chk("err", err, (ven && ld != rb) ? 1 : 0);
        chk("extra_ready", xready, 0);
        chk("bit_count", cap.size() - base, ven ? 2 * CL : CL);
        got = '0;
        for (int i = 0; i < CL; i++)
            if (base + i < cap.size()) got[CL-1-i] = cap[base+i];
        chk("head_bits", got, expv);
        if (!flip) begin
            chk("chain_image", chain, expv);
            if (ven) begin
                got = '0;
                for (int i = 0; i < CL; i++)
                    if (base + CL + i < cap.size())
                        got[CL-1-i] = cap[base+CL+i];
                chk("verify_bits", got, expv);
            end
        end
        @(negedge prog_clk);
        chk("done_once", done, 0);
        chk("idle", busy, 0);
    endtask

    initial begin
        int base;
        int t;
        #1;
        chk("reset_outs", {cfg_ready, ccff_head, chain_en, busy, done, err}, 0);
        repeat (3) @(negedge prog_clk);
        pReset_n = 1'b1;
        @(negedge prog_clk);

        wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hF0;
        gq[0] = 0; gq[1] = 0; gq[2] = 0;
        run_session(0, 0, 0);
        run_session(1, 0, 0);
        run_session(1, 1, 0);
        repeat (3) @(negedge prog_clk);
        chk("err_sticky", err, 1);

        gq[1] = 5;
        run_session(0, 0, 0);
        gq[1] = 0;
        run_session(0, 0, 1);

        base = cap.size();
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 8'h5A;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        t = 0;
        while (cap.size() - base < 6 && t < 50) begin
            @(negedge prog_clk);
            t++;
        end
        chk("reached_shift7", cap.size() - base, 6);
        #1 pReset_n = 1'b0;
        #1;
        chk("midreset_outs",
            {cfg_ready, ccff_head, chain_en, busy, done, err}, 0);
        @(negedge prog_clk);
        pReset_n = 1'b1;
        @(negedge prog_clk);
        chk("no_done_after_abort", done, 0);
        run_session(0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < NW; k++) begin
                wq[k] = WW'($urandom);
                gq[k] = $urandom_range(0, 3);
            end
            run_session(1'($urandom_range(0, 1)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
